jk_bank_arbiter: RTL
====================

// Module: jk_bank_arbiter
// PURPOSE
//  Shares one WIDTH-bit bank of level-sensitive JK latch cells between NUM_REQ requesters.
//  Each request carries a command (hold/reset/set/toggle) and a bit mask.
//  Sits between requester logic and the latch bank; drives the bank's J, K and Enable pins.
//  Requesters are granted round-robin. Enable is sequenced so J/K are stable around the Enable pulse.
//  Toggle is converted to explicit set/reset from Q feedback, so the bank never sees J=K=1 while enabled.
// PARAMETERS
//  NUM_REQ       4  number of requesters (2..8)
//  WIDTH         8  latch bank width in bits
//  PULSE_CYCLES  2  Enable high time in Clk cycles (>=1)
// PORTS
//  Clk      in   1              system clock, rising edge
//  Clear    in   1              asynchronous reset, active low
//  Req      in   NUM_REQ        request level per requester
//  Cmd      in   2*NUM_REQ      command of requester i at [2i+1:2i]: 00 hold, 01 reset, 10 set, 11 toggle
//  Mask     in   WIDTH*NUM_REQ  bit mask of requester i at [WIDTH*i +: WIDTH]
//  Q        in   WIDTH          latch bank Q feedback
//  J        out  WIDTH          latch bank J drive
//  K        out  WIDTH          latch bank K drive
//  Enable   out  1              latch bank enable
//  Grant    out  NUM_REQ        one-hot owner of the current operation
//  Ack      out  NUM_REQ        one-cycle completion pulse to the owner
//  Busy     out  1              high whenever state != IDLE
// BEHAVIOUR
//  Reset (Clear=0, takes effect at once): J=0, K=0, Enable=0, Grant=0, Ack=0, Busy=0.
//    State=IDLE; round-robin pointer=0, so requester 0 has highest priority first.
//  FSM: IDLE -> SETUP -> PULSE (PULSE_CYCLES cycles) -> HOLD -> IDLE.
//  IDLE: at a Clk edge with any Req high, select the first Req at or after the pointer (wrapping).
//    Register Grant, set J/K from the selected Cmd/Mask, go to SETUP.
//    Pointer moves to winner+1 mod NUM_REQ.
//  J/K per bit b (m=Mask[b], q=Q[b], sampled at the IDLE->SETUP edge):
//    hold:   J=0,   K=0
//    reset:  J=0,   K=m
//    set:    J=m,   K=0
//    toggle: J=m&~q, K=m&q
//  SETUP: Enable=0, J/K stable, 1 cycle.
//  PULSE: Enable=1 for exactly PULSE_CYCLES cycles. J/K frozen; Q changes are ignored.
//  HOLD: Enable=0, J/K still held, Ack[owner]=1 for this cycle only. Next edge -> IDLE.
//  On return to IDLE, J/K return to 0 and Grant clears.
//  Latency: Req sampled at edge E0 -> Enable high from E1 to E(1+PULSE_CYCLES).
//    -> Ack high from E(1+PULSE_CYCLES) to E(2+PULSE_CYCLES).
//  At least one IDLE cycle separates consecutive operations.
//  Handshake: requester holds Req/Cmd/Mask until it sees Ack and drops Req in the Ack cycle.
//    A Req still high in the IDLE cycle after Ack is a new request.
//    Cmd/Mask changes after grant are ignored.
//  Simultaneous Req: round-robin order only; no starvation. With all NUM_REQ requesting, each is served once per NUM_REQ ops.
//  Mask=0 or hold command: full sequence still runs (Enable pulses, Ack issued); the bank does not change.
//  Req dropped after grant: the operation completes and Ack is still pulsed.
//  Clear asserted mid-operation: immediate reset values. Operation aborted, no Ack; the bank keeps its Q.
//  Out-of-range Grant is impossible: Grant is always one-hot or zero.
// CONFIGURATION
//  JK_BANK_OPCOUNT_EN defined:
//    Adds output OpCount[15:0], reset 0.
//    Increments by 1 on the edge that ends each HOLD state and wraps 16'hFFFF -> 0.
//    Aborted operations are not counted.
//  Undefined: no OpCount port and no counter logic; all other behaviour is identical.
// TESTING (NUM_REQ=4, WIDTH=8, PULSE_CYCLES=2, behavioural JK latch bank model with Q from 8'h00)
//  Single set: Req=4'b0001, Cmd0=10, Mask0=8'h0F.
//    -> J=8'h0F, K=0 at E1; Enable high 2 cycles; Ack[0] at E3.
//    -> Q=8'h0F; Busy high for 4 cycles.
//  Toggle without race: Q=8'h0F, requester 2 toggle, Mask=8'hFF.
//    -> J=8'hF0, K=8'h0F (never J=K=1); Q=8'hF0 after the pulse.
//  Round-robin: Req=4'b1111 held, each dropped after its own Ack.
//    -> Grant order 0,1,2,3; with ops 1,3 re-requesting, next order is 1,3.
//  Boundary: Mask=0 set, then hold command.
//    -> Enable pulses and Ack issued both times; Q unchanged.
//    -> Req kept high after Ack yields a second grant after one IDLE cycle.
//  Reset mid-PULSE: Clear=0 while Enable=1.
//    -> Enable, J, K, Grant, Busy go to 0 at once, no Ack.
//    -> After Clear=1, pointer=0 and requester 0 wins first.
//  JK_BANK_OPCOUNT_EN: 3 completed ops plus 1 aborted op -> OpCount=3.
//    Force OpCount=16'hFFFF, complete 1 op -> OpCount=0.

Source files
------------

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter that sequences J/K/Enable for a shared bank of level-sensitive JK latches.
// Optional OpCount output (completed-operation counter) when JK_BANK_OPCOUNT_EN is defined.
module jk_bank_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned PULSE_CYCLES = 2
) (
    input  logic                       Clk,
    input  logic                       Clear,
    input  logic [NUM_REQ-1:0]         Req,
    input  logic [2*NUM_REQ-1:0]       Cmd,
    input  logic [WIDTH*NUM_REQ-1:0]   Mask,
    input  logic [WIDTH-1:0]           Q,
    output logic [WIDTH-1:0]           J,
    output logic [WIDTH-1:0]           K,
    output logic                       Enable,
    output logic [NUM_REQ-1:0]         Grant,
    output logic [NUM_REQ-1:0]         Ack,
    output logic                       Busy
`ifdef JK_BANK_OPCOUNT_EN
    ,
    output logic [15:0]                OpCount
`endif
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_e;

    state_e               state_q;
    logic [PW-1:0]        ptr_q;
    logic [CW-1:0]        cnt_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic [WIDTH-1:0]     j_q;
    logic [WIDTH-1:0]     k_q;
    logic                 en_q;
    logic                 busy_q;

    logic                 found_c;
    logic [PW-1:0]        win_c;
    logic [PW-1:0]        ptr_d;
    logic [1:0]           cmd_c;
    logic [WIDTH-1:0]     mask_c;
    logic [WIDTH-1:0]     j_d;
    logic [WIDTH-1:0]     k_d;
    logic [NUM_REQ-1:0]   grant_d;
    int                   best_c;
    int                   dist_c;

    // Winner = requester with the smallest wrapped distance from the pointer; toggle resolved from Q.
    always_comb begin
        found_c = 1'b0;
        win_c   = '0;
        best_c  = int'(NUM_REQ);
        dist_c  = 0;
        for (int c = 0; c < int'(NUM_REQ); c++) begin
            dist_c = (c + int'(NUM_REQ) - int'(ptr_q)) % int'(NUM_REQ);
            if (Req[c] && (dist_c < best_c)) begin
                best_c  = dist_c;
                win_c   = PW'(c);
                found_c = 1'b1;
            end
        end

        cmd_c  = 2'b00;
        mask_c = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (win_c == PW'(i)) begin
                cmd_c  = Cmd[2*i +: 2];
                mask_c = Mask[WIDTH*i +: WIDTH];
            end
        end

        case (cmd_c)
            2'b01:   begin j_d = '0;            k_d = mask_c;        end
            2'b10:   begin j_d = mask_c;        k_d = '0;            end
            2'b11:   begin j_d = mask_c & ~Q;   k_d = mask_c & Q;    end
            default: begin j_d = '0;            k_d = '0;            end
        endcase

        ptr_d   = (win_c == PW'(NUM_REQ - 1)) ? '0 : win_c + PW'(1);
        grant_d = NUM_REQ'(1) << win_c;
    end

    // Operation sequencer: IDLE -> SETUP -> PULSE x PULSE_CYCLES -> HOLD -> IDLE.
    always_ff @(posedge Clk or negedge Clear) begin
        if (!Clear) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            j_q     <= '0;
            k_q     <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found_c) begin
                        state_q <= SETUP;
                        grant_q <= grant_d;
                        j_q     <= j_d;
                        k_q     <= k_d;
                        busy_q  <= 1'b1;
                        ptr_q   <= ptr_d;
                    end
                end
                SETUP: begin
                    state_q <= PULSE;
                    en_q    <= 1'b1;
                    cnt_q   <= '0;
                end
                PULSE: begin
                    if (cnt_q == CW'(PULSE_CYCLES - 1)) begin
                        state_q <= HOLD;
                        en_q    <= 1'b0;
                        ack_q   <= grant_q;
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                HOLD: begin
                    state_q <= IDLE;
                    ack_q   <= '0;
                    grant_q <= '0;
                    j_q     <= '0;
                    k_q     <= '0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef JK_BANK_OPCOUNT_EN
    logic [15:0] opcount_q;

    // Counts operations that reach the end of HOLD; an abort via Clear never gets there.
    always_ff @(posedge Clk or negedge Clear) begin
        if (!Clear) begin
            opcount_q <= '0;
        end else if (state_q == HOLD) begin
            opcount_q <= opcount_q + 16'd1;
        end
    end

    assign OpCount = opcount_q;
`endif

    assign J      = j_q;
    assign K      = k_q;
    assign Enable = en_q;
    assign Grant  = grant_q;
    assign Ack    = ack_q;
    assign Busy   = busy_q;

endmodule
